// File: rtl/mux4_arb_pkg.sv
// Shared types and the rotating-priority search for the 4-way arbiter.
// Imported by the arbiter top; keeps widths in one place.
package mux4_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Reverse scan so the index nearest ptr is assigned last and wins.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [SEL_W-1:0] ptr
    );
        logic [SEL_W-1:0] idx;
        rr_pick = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/mux_4to1.sv
// Shared 4:1 bit multiplexer driven by the arbiter select.
// Purely combinational.
module mux_4to1 (
    input  logic [3:0] a,
    input  logic [1:0] sel,
    output logic       y
);

    assign y = a[sel];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one mux_4to1 among four requesters.
// Grants are held for at most HOLD_MAX cycles, released early on drop.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] a,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       y,
    output logic       y_valid,
    output logic       busy
);

    localparam int CW = $clog2(HOLD_MAX + 1);

    arb_state_t       state;
    logic [SEL_W-1:0] owner;
    logic [SEL_W-1:0] ptr;
    logic [CW-1:0]    hold_cnt;

    logic             rel;
    logic [SEL_W-1:0] ptr_nxt;
    logic [SEL_W-1:0] win;
    logic             found;

    always_comb begin
        rel     = !req[owner] || (hold_cnt == CW'(HOLD_MAX));
        ptr_nxt = ptr;
        if (state == OWN && rel) ptr_nxt = owner + 2'd1;
        win     = rr_pick(req, ptr_nxt);
        found   = |req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state    <= OWN;
                        owner    <= win;
                        hold_cnt <= CW'(1);
                    end
                end
                OWN: begin
                    if (!rel) begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end else begin
                        ptr <= ptr_nxt;
                        if (found) begin
                            owner    <= win;
                            hold_cnt <= CW'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode only registered state, so reset clears them at once.
    assign y_valid = (state == OWN);
    assign busy    = y_valid;
    assign sel     = owner;
    assign grant   = y_valid ? (4'b0001 << owner) : 4'b0000;

    mux_4to1 u_mux (
        .a  (a),
        .sel(sel),
        .y  (y)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with a priority-list reference model.
// Two instances: HOLD_MAX=4 and HOLD_MAX=1.
module tb_mux4_rr_arbiter;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      a = 4'b0100;
    logic [1:0][3:0] rq = '0;
    logic [1:0][3:0] gnt;
    logic [1:0][1:0] sl;
    logic [1:0]      yy;
    logic [1:0]      vld;
    logic [1:0]      bsy;

    int vectors = 0;
    int errors  = 0;

    int m_own   [2];
    int m_owner [2];
    int m_held  [2];
    int m_base  [2];
    int hmax    [2] = '{4, 1};

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.HOLD_MAX(4)) d4 (
        .clk(clk), .rst_n(rst_n), .req(rq[0]), .a(a),
        .grant(gnt[0]), .sel(sl[0]), .y(yy[0]),
        .y_valid(vld[0]), .busy(bsy[0])
    );

    mux4_rr_arbiter #(.HOLD_MAX(1)) d1 (
        .clk(clk), .rst_n(rst_n), .req(rq[1]), .a(a),
        .grant(gnt[1]), .sel(sl[1]), .y(yy[1]),
        .y_valid(vld[1]), .busy(bsy[1])
    );

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_own[d]   = 0;
            m_owner[d] = 0;
            m_held[d]  = 0;
            m_base[d]  = 0;
        end
    endtask

    // Owner keeps the line while requesting and under its budget;
    // otherwise the priority list restarts just after the owner.
    task automatic model_step(input int d, input logic [3:0] r);
        int idx;
        if (m_own[d] != 0) begin
            if (r[m_owner[d]] && m_held[d] < hmax[d]) begin
                m_held[d]++;
                return;
            end
            m_base[d] = (m_owner[d] + 1) % 4;
            m_own[d]  = 0;
        end
        for (int k = 0; k < 4; k++) begin
            idx = (m_base[d] + k) % 4;
            if (r[idx]) begin
                m_own[d]   = 1;
                m_owner[d] = idx;
                m_held[d]  = 1;
                break;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at %0t",
                     nm, act, exp, $time);
        end
    endtask

    initial model_reset();
    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n) begin
            model_step(0, rq[0]);
            model_step(1, rq[1]);
        end
    end

    always @(negedge clk) begin
        logic [3:0] eg;
        logic [3:0] av;
        av = a;
        for (int d = 0; d < 2; d++) begin
            eg = (m_own[d] != 0) ? 4'(1 << m_owner[d]) : 4'b0000;
            chk($sformatf("grant[%0d]", d), gnt[d], eg);
            chk($sformatf("sel[%0d]", d), {2'b00, sl[d]},
                4'(m_owner[d]));
            chk($sformatf("y[%0d]", d), {3'b000, yy[d]},
                {3'b000, av[m_owner[d]]});
            chk($sformatf("y_valid[%0d]", d), {3'b000, vld[d]},
                4'(m_own[d] != 0));
            chk($sformatf("busy[%0d]", d), {3'b000, bsy[d]},
                4'(m_own[d] != 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rq    = '0;
        ticks(2);
        rst_n = 1'b1;
    endtask

    initial begin
        // 1: reset then single requester
        #2;
        chk("rst grant", gnt[0], 4'b0000);
        chk("rst y_valid", {3'b0, vld[0]}, 4'b0000);
        chk("rst y", {3'b0, yy[0]}, 4'b0000);
        ticks(2);
        rst_n = 1'b1;
        tick();
        rq[0] = 4'b0100;
        tick();
        chk("t1 grant", gnt[0], 4'b0100);
        chk("t1 sel", {2'b0, sl[0]}, 4'd2);
        chk("t1 y", {3'b0, yy[0]}, 4'b0001);
        ticks(4);
        chk("t1 regrant", gnt[0], 4'b0100);
        ticks(7);

        // 2: contention 1010
        do_reset();
        rq[0] = 4'b1010;
        tick();
        chk("t2 first", gnt[0], 4'b0010);
        ticks(3);
        chk("t2 hold4", gnt[0], 4'b0010);
        tick();
        chk("t2 swap", gnt[0], 4'b1000);
        ticks(4);
        chk("t2 back", gnt[0], 4'b0010);
        ticks(6);

        // 3: all four, y tracks a[owner]
        do_reset();
        rq[0] = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            a = 4'($urandom_range(0, 15));
            tick();
            if (i == 4) chk("t3 owner1", gnt[0], 4'b0010);
            if (i == 16) chk("t3 wrap0", gnt[0], 4'b0001);
        end

        // 4: early release with req[3] pending
        do_reset();
        rq[0] = 4'b1010;
        ticks(2);
        chk("t4 held2", gnt[0], 4'b0010);
        rq[0] = 4'b1000;
        #3;
        chk("t4 drop cycle", gnt[0], 4'b0010);
        tick();
        chk("t4 next", gnt[0], 4'b1000);
        chk("t4 ptr", {2'b0, d4.ptr}, 4'd2);
        ticks(3);

        // 5: HOLD_MAX = 1 alternation
        do_reset();
        rq[1] = 4'b0011;
        tick();
        chk("t5 g0", gnt[1], 4'b0001);
        tick();
        chk("t5 g1", gnt[1], 4'b0010);
        tick();
        chk("t5 g0b", gnt[1], 4'b0001);
        ticks(5);

        // 6: reset mid-grant, ptr returns to 0
        do_reset();
        rq[0] = 4'b0100;
        ticks(6);
        chk("t6 pre", gnt[0], 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 async grant", gnt[0], 4'b0000);
        chk("t6 async sel", {2'b0, sl[0]}, 4'd0);
        chk("t6 async vld", {3'b0, vld[0]}, 4'b0000);
        tick();
        rq[0] = 4'b1100;
        rst_n = 1'b1;
        tick();
        chk("t6 first", gnt[0], 4'b0100);
        ticks(6);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
